// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one RW memory port: round-robin grant, grant lock while stalled,
// in-order read-response routing. Define MEM_ARB_FIXED_PRIO_EN to give M1 fixed priority.
module mem_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic            m0_write,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    output logic            m0_ready,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,

    input  logic            m1_req,
    input  logic            m1_write,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m1_ready,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,

    output logic            s_req,
    output logic            s_write,
    output logic [DW/8-1:0] s_wstrb,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    input  logic            s_ready,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata,

    output logic            err_rvalid
);

    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t        r_state;
    lock_state_t        w_state_nxt;
    logic               r_lock_id;
    logic [MAX_OUT-1:0] r_fifo;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_elig0;
    logic               w_elig1;
    logic               w_req;
    logic               w_gnt;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_head;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic               r_rr_last;
`endif

    assign w_full  = (r_count == CW'(MAX_OUT));
    assign w_empty = (r_count == '0);
    assign w_elig0 = m0_req & ~w_full;
    assign w_elig1 = m1_req & ~w_full;

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        w_req = 1'b0;
        w_gnt = 1'b0;
        if (r_state == LOCKED) begin
            w_gnt = r_lock_id;
            w_req = r_lock_id ? m1_req : m0_req;
        end else if (w_elig0 && w_elig1) begin
            w_req = 1'b1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            w_gnt = 1'b1;
`else
            w_gnt = ~r_rr_last;
`endif
        end else if (w_elig0) begin
            w_req = 1'b1;
            w_gnt = 1'b0;
        end else if (w_elig1) begin
            w_req = 1'b1;
            w_gnt = 1'b1;
        end
    end

    // Outputs are combinational, so reset must gate them directly.
    assign s_req   = w_req & ~rst;
    assign s_write = w_gnt ? m1_write : m0_write;
    assign s_wstrb = w_gnt ? m1_wstrb : m0_wstrb;
    assign s_addr  = w_gnt ? m1_addr  : m0_addr;
    assign s_wdata = w_gnt ? m1_wdata : m0_wdata;

    assign w_accept = s_req & s_ready;
    assign m0_ready = w_accept & ~w_gnt;
    assign m1_ready = w_accept &  w_gnt;

    assign w_push = w_accept & ~s_write;
    assign w_pop  = s_rvalid & ~w_empty & ~rst;
    assign w_head = r_fifo[r_rd_ptr];

    assign m0_rvalid  = w_pop & ~w_head;
    assign m1_rvalid  = w_pop &  w_head;
    assign m0_rdata   = s_rdata;
    assign m1_rdata   = s_rdata;
    assign err_rvalid = r_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UNLOCKED: if (s_req && !s_ready) w_state_nxt = LOCKED;
            LOCKED:   if (s_ready)           w_state_nxt = UNLOCKED;
            default:                         w_state_nxt = UNLOCKED;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= UNLOCKED;
            r_lock_id <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == UNLOCKED && s_req && !s_ready) begin
                r_lock_id <= w_gnt;
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_rr_last <= w_gnt;
        end
    end
`endif

    // NOTE: the id storage is only a few flops, so it is reset along with the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_gnt;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (s_rvalid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-strobed memory model (1-cycle read latency).
// Build with MEM_ARB_FIXED_PRIO_EN to exercise fixed-priority grant instead of round-robin.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic m0_req, m0_write, m0_ready, m0_rvalid;
    logic [3:0]  m0_wstrb;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic m1_req, m1_write, m1_ready, m1_rvalid;
    logic [3:0]  m1_wstrb;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic s_req, s_write, s_ready, s_rvalid;
    logic [3:0]  s_wstrb;
    logic [11:0] s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic err_rvalid;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    logic [31:0] pend[$];
    logic [31:0] mem [0:4095];
    logic rsp_en;
    logic spur;
    int   rsp_one_req  = 0;
    int   rsp_one_done = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_write(m0_write), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .err_rvalid(err_rvalid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_rd(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50 && (sb.size() > 0 || pend.size() > 0); i++) @(negedge clk);
        check("drain_scoreboard", sb.size(), 0);
    endtask

    // Memory model: capture accepted transfers mid-cycle, return read data on the next cycle.
    always @(negedge clk) begin
        if (s_req && s_ready) begin
            if (s_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wstrb[b]) mem[s_addr][b*8 +: 8] = s_wdata[b*8 +: 8];
                end
            end else begin
                pend.push_back(mem[s_addr]);
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (spur) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && (rsp_en || rsp_one_req != rsp_one_done)) begin
            s_rvalid = 1'b1;
            s_rdata  = pend.pop_front();
            if (rsp_one_req != rsp_one_done) rsp_one_done++;
        end else begin
            s_rvalid = 1'b0;
        end
    end

    // Response monitor: every routed read must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (m0_rvalid || m1_rvalid)) begin
            check("rsp_one_port_only", {m0_rvalid, m1_rvalid} == 2'b11, 0);
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_port", m1_rvalid, e.port);
                check("rsp_data", m1_rvalid ? m1_rdata : m0_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + i;
        rst = 1'b1;
        m0_req = 1'b1; m0_write = 1'b0; m0_wstrb = 4'h0; m0_addr = 12'h010; m0_wdata = '0;
        m1_req = 1'b1; m1_write = 1'b0; m1_wstrb = 4'h0; m1_addr = 12'h020; m1_wdata = '0;
        s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;
        rsp_en = 1'b0; spur = 1'b0;

        @(negedge clk);
        check("rst_s_req", s_req, 0);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("rst_err", err_rvalid, 0);
        drive_edge();
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;

`ifndef MEM_ARB_FIXED_PRIO_EN
        // Round-robin: both requesting, grants alternate starting with M0.
        drive_edge();
        m0_req = 1'b1; m1_req = 1'b1; rsp_en = 1'b1;
        for (int i = 0; i < 5; i++) expect_rd(i % 2, (i % 2) ? 32'hC0DE_0020 : 32'hC0DE_0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rr_m0_ready", m0_ready, (i % 2 == 0));
            check("rr_m1_ready", m1_ready, (i % 2 == 1));
            check("rr_s_addr", s_addr, (i % 2) ? 12'h020 : 12'h010);
            drive_edge();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        wait_drain();
`endif

        // Stall lock: M0 held through three not-ready cycles while M1 arrives.
        drive_edge();
        rsp_en = 1'b1; s_ready = 1'b0;
        m0_req = 1'b1; m0_addr = 12'h030; m1_addr = 12'h040;
        expect_rd(0, 32'hC0DE_0030);
        expect_rd(1, 32'hC0DE_0040);
        @(negedge clk);
        check("lock_s_req", s_req, 1);
        check("lock_s_addr0", s_addr, 12'h030);
        check("lock_m0_ready0", m0_ready, 0);
        for (int i = 0; i < 2; i++) begin
            drive_edge();
            m1_req = 1'b1;
            @(negedge clk);
            check("lock_s_addr", s_addr, 12'h030);
            check("lock_m1_ready", m1_ready, 0);
        end
        drive_edge();
        s_ready = 1'b1;
        @(negedge clk);
        check("lock_m0_accept", m0_ready, 1);
        check("lock_m1_wait", m1_ready, 0);
        check("lock_s_addr_acc", s_addr, 12'h030);
        drive_edge();
        m0_req = 1'b0;
        @(negedge clk);
        check("lock_m1_next", m1_ready, 1);
        check("lock_m1_addr", s_addr, 12'h040);
        drive_edge();
        m1_req = 1'b0;
        wait_drain();

        // Outstanding limit: four reads fill the ID FIFO, fifth waits for a response.
        drive_edge();
        rsp_en = 1'b0; m0_req = 1'b1; m0_addr = 12'h100;
        for (int i = 0; i < 5; i++) expect_rd(0, 32'hC0DE_0100 + i);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_fill_ready", m0_ready, 1);
            check("full_fill_addr", s_addr, 12'h100 + i);
            drive_edge();
            m0_addr = 12'h101 + i;
        end
        @(negedge clk);
        check("full_block", s_req, 0);
        drive_edge();
        @(negedge clk);
        check("full_block2", s_req, 0);
        drive_edge();
        rsp_one_req++;
        @(negedge clk);
        check("full_pop_rvalid", m0_rvalid, 1);
        check("full_bubble", s_req, 0);
        drive_edge();
        @(negedge clk);
        check("full_resume", m0_ready, 1);
        check("full_resume_addr", s_addr, 12'h104);
        drive_edge();
        m0_req = 1'b0; rsp_en = 1'b1;
        wait_drain();

        // Byte-strobed write from M1, then M0 reads the merged word.
        drive_edge();
        m1_req = 1'b1; m1_write = 1'b1; m1_wstrb = 4'b0010; m1_addr = 12'h005;
        m1_wdata = 32'hAABB_CCDD;
        @(negedge clk);
        check("wr_m1_ready", m1_ready, 1);
        check("wr_s_write", s_write, 1);
        check("wr_s_wstrb", s_wstrb, 4'b0010);
        check("wr_s_wdata", s_wdata, 32'hAABB_CCDD);
        drive_edge();
        m1_req = 1'b0; m1_write = 1'b0;
        m0_req = 1'b1; m0_addr = 12'h005;
        expect_rd(0, 32'hC0DE_CC05);
        @(negedge clk);
        check("wr_rd_m0_ready", m0_ready, 1);
        check("wr_rd_s_write", s_write, 0);
        drive_edge();
        m0_req = 1'b0;
        wait_drain();

`ifdef MEM_ARB_FIXED_PRIO_EN
        // Fixed priority: M1 wins every cycle while both request.
        drive_edge();
        m0_req = 1'b1; m0_addr = 12'h060; m1_req = 1'b1; m1_addr = 12'h050;
        for (int i = 0; i < 4; i++) expect_rd(1, 32'hC0DE_0050);
        expect_rd(0, 32'hC0DE_0060);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fp_m1_ready", m1_ready, 1);
            check("fp_m0_ready", m0_ready, 0);
            drive_edge();
        end
        m1_req = 1'b0;
        @(negedge clk);
        check("fp_m0_after", m0_ready, 1);
        check("fp_m0_addr", s_addr, 12'h060);
        drive_edge();
        m0_req = 1'b0;
        wait_drain();
`endif

        // Spurious response: sticky error, nothing routed, cleared only by reset.
        drive_edge();
        spur = 1'b1;
        @(negedge clk);
        check("spur_no_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("spur_err_pre", err_rvalid, 0);
        drive_edge();
        spur = 1'b0;
        @(negedge clk);
        check("spur_err_set", err_rvalid, 1);
        for (int i = 0; i < 3; i++) drive_edge();
        @(negedge clk);
        check("spur_err_sticky", err_rvalid, 1);
        drive_edge();
        rst = 1'b1; m0_req = 1'b1; m0_addr = 12'h010;
        #2;
        check("async_rst_err", err_rvalid, 0);
        check("async_rst_s_req", s_req, 0);
        check("async_rst_m0_ready", m0_ready, 0);
        drive_edge();
        rst = 1'b0; m0_req = 1'b0;
        drive_edge();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
